// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
//
// Shared definitions for the instruction/data bus arbiter:
//   - arbState_t : arbiter FSM states (IDLE, ADDR, DATA)
//   - owner_t    : which requester currently owns the shared bus
//   - SIZE_*     : SRAM-like transfer size codes (byte / half / word)
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Arbiter FSM. Only one bus transaction can be in flight at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arbState_t;

    // Bus owner. Inst is the zero encoding so a cleared register means inst.
    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    // Transfer size codes shared by the requesters and the SRAM-like bus.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Merges the fetch (inst) port and the mem-stage (data) port onto one
// SRAM-like master bus. Data has fixed priority over inst. The winning
// request is captured into one register group on grant, and the bus is
// driven only from that group, so requesters may change their inputs freely
// while the transaction is in flight.
//
// Ports
//   clk, rst                       : clock, synchronous active-low reset
//   inst_req, inst_addr            : fetch read request (held until data_ok)
//   inst_rdata, inst_data_ok       : fetch read data and completion pulse
//   data_req, data_wr, data_size   : mem-stage request, write flag, size
//   data_addr, data_wdata          : mem-stage address and write data
//   data_rdata, data_data_ok       : mem-stage read data and completion pulse
//   bus_req, bus_wr, bus_size      : shared master request / write / size
//   bus_addr, bus_wdata            : shared master address / write data
//   bus_addr_ok, bus_data_ok       : slave address accept / data responses
//   bus_rdata                      : slave read data
//   inst_stall, data_stall         : requester pending and not completing
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              inst_stall,
    output logic              data_stall
);

    // Everything captured at grant time travels together as one group.
    typedef struct packed {
        owner_t            owner;
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } reqFields_t;

    arbState_t  state;
    arbState_t  nextState;
    reqFields_t latched;
    reqFields_t grantFields;
    logic       grant;
    logic       busReqRaw;
    logic       complete;

    // Fixed-priority selection of the request that would be captured if a
    // grant happens this cycle. Fetches are always word reads.
    always_comb begin
        grantFields = '0;
        if (data_req) begin
            grantFields.owner = OWNER_DATA;
            grantFields.wr    = data_wr;
            grantFields.size  = data_size;
            grantFields.addr  = data_addr;
            grantFields.wdata = data_wdata;
        end else begin
            grantFields.owner = OWNER_INST;
            grantFields.wr    = 1'b0;
            grantFields.size  = SIZE_WORD;
            grantFields.addr  = inst_addr;
            grantFields.wdata = '0;
        end
    end

    // State register and request capture. Reset clears the owner back to
    // inst and zeroes every captured field, abandoning any open transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            latched <= '0;
        end else begin
            state <= nextState;
            if (grant) begin
                latched <= grantFields;
            end
        end
    end

    // Next-state logic. A response arriving together with the address
    // accept finishes the transfer straight from ADDR. Stray data responses
    // while IDLE fall through the IDLE branch and are ignored.
    always_comb begin
        nextState = state;
        grant     = 1'b0;
        busReqRaw = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    grant     = 1'b1;
                    nextState = ADDR;
                end
            end
            ADDR: begin
                busReqRaw = 1'b1;
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        complete  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    complete  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held so that a response landing
    // in the reset cycle cannot leak out as a completion pulse.
    assign bus_req      = rst & busReqRaw;
    assign bus_wr       = rst & latched.wr;
    assign bus_size     = rst ? latched.size  : 2'b00;
    assign bus_addr     = rst ? latched.addr  : '0;
    assign bus_wdata    = rst ? latched.wdata : '0;

    assign inst_data_ok = rst & complete & (latched.owner == OWNER_INST);
    assign data_data_ok = rst & complete & (latched.owner == OWNER_DATA);

    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign inst_stall   = rst & inst_req & ~inst_data_ok;
    assign data_stall   = rst & data_req & ~data_data_ok;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter. Each scenario task drives the
// requesters and the slave responses cycle by cycle and checks the bus side
// inline. Expected completions are queued when a request is issued and
// popped by a monitor whenever a *_data_ok pulse appears.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_data_ok;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_data_ok;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;
    logic              inst_stall;
    logic              data_stall;

    typedef struct {
        logic              isData;
        logic [DATA_W-1:0] rdata;
    } expect_t;

    expect_t expQ[$];
    int      vectors     = 0;
    int      miscompares = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .inst_stall   (inst_stall),
        .data_stall   (data_stall)
    );

    // Completion monitor: every data_ok pulse must match the oldest queued
    // expectation in owner and read data.
    always @(negedge clk) begin : monitor
        expect_t e;
        logic [DATA_W-1:0] got;
        if (inst_data_ok === 1'b1 || data_data_ok === 1'b1) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_pulse inst_data_ok=%0b data_data_ok=%0b required no pulse",
                         inst_data_ok, data_data_ok);
            end else begin
                e   = expQ.pop_front();
                got = e.isData ? data_rdata : inst_rdata;
                if (data_data_ok !== e.isData || inst_data_ok !== !e.isData || got !== e.rdata) begin
                    miscompares++;
                    $display("[TB] FAIL completion got inst_ok=%0b data_ok=%0b rdata=%h required isData=%0b rdata=%h",
                             inst_data_ok, data_data_ok, got, e.isData, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = '0;
        data_wdata  = '0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clearInputs();
        inst_req    = 1'b1;
        data_req    = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h55AA55AA;
        repeat (2) tick();
        @(negedge clk);
        vectors++;
        if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_wr !== 1'b0 || bus_size !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus got req=%0b addr=%h wr=%0b size=%0d required all 0",
                     bus_req, bus_addr, bus_wr, bus_size);
        end
        vectors++;
        if (inst_stall !== 1'b0 || data_stall !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status got istall=%0b dstall=%0b iok=%0b dok=%0b required all 0",
                     inst_stall, data_stall, inst_data_ok, data_data_ok);
        end
        vectors++;
        if (inst_rdata !== 32'h55AA55AA) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata_passthru got %h required %h", inst_rdata, 32'h55AA55AA);
        end
        tick();
        rst      = 1'b1;
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || bus_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_stray_ok got iok=%0b dok=%0b req=%0b required 0 0 0",
                     inst_data_ok, data_data_ok, bus_req);
        end
        tick();
        clearInputs();
        @(negedge clk);
        vectors++;
        if (bus_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_stays got req=%0b required 0", bus_req);
        end
    endtask

    task automatic test_single_fetch();
        int busReqCycles = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            case (c)
                0: begin
                    inst_req  = 1'b1;
                    inst_addr = 32'hBFC00000;
                    expQ.push_back('{1'b0, 32'h24080001});
                end
                2: bus_addr_ok = 1'b1;
                3: bus_addr_ok = 1'b0;
                4: begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = 32'h24080001;
                end
                5: clearInputs();
                default: ;
            endcase
            @(negedge clk);
            if (bus_req === 1'b1) busReqCycles++;
            if (c == 1) begin
                vectors++;
                if (bus_addr !== 32'hBFC00000 || bus_wr !== 1'b0 || bus_size !== SIZE_WORD) begin
                    miscompares++;
                    $display("[TB] FAIL fetch_bus got addr=%h wr=%0b size=%0d required bfc00000 0 2",
                             bus_addr, bus_wr, bus_size);
                end
            end
            if (c == 3) begin
                vectors++;
                if (inst_stall !== 1'b1 || bus_req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL fetch_data_wait got stall=%0b req=%0b required 1 0",
                             inst_stall, bus_req);
                end
            end
            if (c == 4) begin
                vectors++;
                if (inst_data_ok !== 1'b1 || inst_stall !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL fetch_done got ok=%0b stall=%0b required 1 0",
                             inst_data_ok, inst_stall);
                end
            end
        end
        vectors++;
        if (busReqCycles != 2) begin
            miscompares++;
            $display("[TB] FAIL fetch_busreq_cycles got %0d required 2", busReqCycles);
        end
    endtask

    task automatic test_priority();
        int stallCycles = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            case (c)
                0: begin
                    inst_req   = 1'b1;
                    inst_addr  = 32'hBFC00004;
                    data_req   = 1'b1;
                    data_wr    = 1'b1;
                    data_size  = SIZE_WORD;
                    data_addr  = 32'h80000010;
                    data_wdata = 32'hDEADBEEF;
                    expQ.push_back('{1'b1, 32'h0});
                    expQ.push_back('{1'b0, 32'h11112222});
                end
                1: bus_addr_ok = 1'b1;
                2: begin
                    bus_addr_ok = 1'b0;
                    bus_data_ok = 1'b1;
                    bus_rdata   = 32'h0;
                end
                3: begin
                    bus_data_ok = 1'b0;
                    data_req    = 1'b0;
                end
                4: begin
                    bus_addr_ok = 1'b1;
                    bus_data_ok = 1'b1;
                    bus_rdata   = 32'h11112222;
                end
                5: clearInputs();
                default: ;
            endcase
            @(negedge clk);
            if (c <= 3 && inst_stall === 1'b1) stallCycles++;
            if (c == 1) begin
                vectors++;
                if (bus_req !== 1'b1 || bus_wr !== 1'b1 || bus_addr !== 32'h80000010 ||
                    bus_wdata !== 32'hDEADBEEF || bus_size !== SIZE_WORD) begin
                    miscompares++;
                    $display("[TB] FAIL prio_data_first got req=%0b wr=%0b addr=%h wdata=%h size=%0d required 1 1 80000010 deadbeef 2",
                             bus_req, bus_wr, bus_addr, bus_wdata, bus_size);
                end
            end
            if (c == 3) begin
                vectors++;
                if (bus_req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL prio_idle_gap got req=%0b required 0", bus_req);
                end
            end
            if (c == 4) begin
                vectors++;
                if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00004 || bus_wr !== 1'b0 ||
                    inst_data_ok !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL prio_inst_second got req=%0b addr=%h wr=%0b ok=%0b required 1 bfc00004 0 1",
                             bus_req, bus_addr, bus_wr, inst_data_ok);
                end
            end
            if (c == 5) begin
                vectors++;
                if (bus_req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL prio_back_idle got req=%0b required 0", bus_req);
                end
            end
        end
        vectors++;
        if (stallCycles != 4) begin
            miscompares++;
            $display("[TB] FAIL prio_inst_stall got %0d cycles required 4", stallCycles);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            tick();
            case (c)
                0: begin
                    data_req  = 1'b1;
                    data_wr   = 1'b0;
                    data_size = SIZE_HALF;
                    data_addr = 32'h80000020;
                    expQ.push_back('{1'b1, 32'hCAFEF00D});
                    expQ.push_back('{1'b1, 32'h0BADF00D});
                end
                1: begin
                    bus_addr_ok = 1'b1;
                    bus_data_ok = 1'b1;
                    bus_rdata   = 32'hCAFEF00D;
                end
                2: begin
                    bus_addr_ok = 1'b0;
                    bus_data_ok = 1'b0;
                    data_addr   = 32'h80000024;
                end
                3: bus_addr_ok = 1'b1;
                4: begin
                    bus_addr_ok = 1'b0;
                    bus_data_ok = 1'b1;
                    bus_rdata   = 32'h0BADF00D;
                end
                5: clearInputs();
                default: ;
            endcase
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (bus_size !== SIZE_HALF || data_data_ok !== 1'b1 || data_stall !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_same_cycle got size=%0d ok=%0b stall=%0b required 1 1 0",
                             bus_size, data_data_ok, data_stall);
                end
            end
            if (c == 2) begin
                vectors++;
                if (bus_req !== 1'b0 || data_stall !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_idle got req=%0b stall=%0b required 0 1", bus_req, data_stall);
                end
            end
            if (c == 3) begin
                vectors++;
                if (bus_req !== 1'b1 || bus_addr !== 32'h80000024) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_regrant got req=%0b addr=%h required 1 80000024", bus_req, bus_addr);
                end
            end
        end
    endtask

    task automatic test_addr_hold();
        for (int c = 0; c < 5; c++) begin
            tick();
            case (c)
                0: begin
                    data_req   = 1'b1;
                    data_wr    = 1'b1;
                    data_size  = SIZE_WORD;
                    data_addr  = 32'h80000040;
                    data_wdata = 32'h12345678;
                    expQ.push_back('{1'b1, 32'h0});
                end
                1: begin
                    data_addr  = 32'hFFFF0000;
                    data_wdata = 32'h0;
                    data_size  = SIZE_BYTE;
                    data_wr    = 1'b0;
                end
                2: bus_addr_ok = 1'b1;
                3: begin
                    bus_addr_ok = 1'b0;
                    bus_data_ok = 1'b1;
                end
                4: clearInputs();
                default: ;
            endcase
            @(negedge clk);
            if (c == 1 || c == 2) begin
                vectors++;
                if (bus_req !== 1'b1 || bus_addr !== 32'h80000040 || bus_wdata !== 32'h12345678 ||
                    bus_size !== SIZE_WORD || bus_wr !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL addr_hold cyc%0d got req=%0b addr=%h wdata=%h size=%0d wr=%0b required 1 80000040 12345678 2 1",
                             c, bus_req, bus_addr, bus_wdata, bus_size, bus_wr);
                end
            end
        end
    endtask

    task automatic test_byte_store();
        for (int c = 0; c < 3; c++) begin
            tick();
            case (c)
                0: begin
                    data_req   = 1'b1;
                    data_wr    = 1'b1;
                    data_size  = SIZE_BYTE;
                    data_addr  = 32'h80000003;
                    data_wdata = 32'h000000AB;
                    expQ.push_back('{1'b1, 32'h0});
                end
                1: begin
                    bus_addr_ok = 1'b1;
                    bus_data_ok = 1'b1;
                end
                2: clearInputs();
                default: ;
            endcase
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (bus_size !== SIZE_BYTE || bus_addr !== 32'h80000003 || bus_wdata !== 32'h000000AB) begin
                    miscompares++;
                    $display("[TB] FAIL byte_store got size=%0d addr=%h wdata=%h required 0 80000003 000000ab",
                             bus_size, bus_addr, bus_wdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 5; c++) begin
            tick();
            case (c)
                0: begin
                    inst_req  = 1'b1;
                    inst_addr = 32'hBFC00010;
                end
                1: bus_addr_ok = 1'b1;
                2: begin
                    bus_addr_ok = 1'b0;
                    rst         = 1'b0;
                    bus_data_ok = 1'b1;
                    bus_rdata   = 32'h77777777;
                end
                3: begin
                    rst      = 1'b1;
                    inst_req = 1'b0;
                end
                4: clearInputs();
                default: ;
            endcase
            @(negedge clk);
            if (c == 2) begin
                vectors++;
                if (inst_data_ok !== 1'b0 || bus_addr !== 32'h0 || inst_stall !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_mid_in_reset got ok=%0b addr=%h stall=%0b required 0 0 0",
                             inst_data_ok, bus_addr, inst_stall);
                end
            end
            if (c == 3 || c == 4) begin
                vectors++;
                if (inst_data_ok !== 1'b0 || bus_req !== 1'b0 || bus_addr !== 32'h0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_mid_after cyc%0d got ok=%0b req=%0b addr=%h required 0 0 0",
                             c, inst_data_ok, bus_req, bus_addr);
                end
            end
        end
    endtask

    initial begin
        clearInputs();
        rst = 1'b0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_back_to_back();
        test_addr_hold();
        test_byte_store();
        test_reset_mid();
        repeat (2) tick();
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pending_completions got %0d left required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width of all ports.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the reset, which is synchronous and active-low.
REQ-005 The block SHALL have inst_req  input  1, inst_addr  input  ADDR_W, meaning the fetch read request, held until inst_data_ok.
REQ-006 The block SHALL have inst_rdata  output  DATA_W, inst_data_ok  output  1, meaning the fetch read data and its one-cycle completion pulse.
REQ-007 The block SHALL have data_req  input  1, data_wr  input  1, data_size  input  2 (0=byte, 1=half, 2=word), meaning the mem-stage request, held until data_data_ok.
REQ-008 The block SHALL have data_addr  input  ADDR_W, data_wdata  input  DATA_W, meaning the mem-stage address and write data.
REQ-009 The block SHALL have data_rdata  output  DATA_W, data_data_ok  output  1, meaning the mem-stage read data and its completion pulse.
REQ-010 The block SHALL have bus_req  output  1, bus_wr  output  1, bus_size  output  2, meaning the shared SRAM-like master request, write flag and size.
REQ-011 The block SHALL have bus_addr  output  ADDR_W, bus_wdata  output  DATA_W, meaning the shared master address and write data.
REQ-012 The block SHALL have bus_addr_ok  input  1, bus_data_ok  input  1, bus_rdata  input  DATA_W, meaning the slave responses.
REQ-013 The block SHALL have inst_stall  output  1, data_stall  output  1, meaning each requester is pending and not completing this cycle; both feed the hazard unit.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR and DATA; at most one bus transaction SHALL be outstanding.
REQ-015 In IDLE with any request, the block SHALL grant data over inst (fixed priority), latch the owner, wr, size, addr and wdata, and go to ADDR.
REQ-016 An inst grant SHALL latch wr=0 and size=2.
REQ-017 In ADDR, bus_req SHALL be 1 and bus_* SHALL come from the latched fields only, so requester changes do not disturb the bus.
REQ-018 In ADDR, bus_addr_ok=1 SHALL move the FSM to DATA; otherwise it SHALL stay in ADDR.
REQ-019 In ADDR, bus_addr_ok=1 and bus_data_ok=1 together SHALL complete the transaction directly and return to IDLE.
REQ-020 In IDLE and DATA, bus_req SHALL be 0.
REQ-021 In DATA, bus_data_ok=1 SHALL pulse the owner's *_data_ok for exactly that cycle and return to IDLE next cycle.
REQ-022 inst_rdata and data_rdata SHALL be combinational pass-throughs of bus_rdata; they are valid only while the matching *_data_ok is 1.
REQ-023 bus_data_ok in IDLE SHALL be ignored, covering stray responses after reset.
REQ-024 Latency SHALL be: request visible in IDLE cycle N; bus_req from N+1; earliest completion in the cycle bus_addr_ok is first seen; next grant one cycle after completion.
REQ-025 The loser of a simultaneous request SHALL be granted at the next IDLE cycle if it is still requesting.
REQ-026 A requester SHALL deassert req the cycle after its data_ok unless issuing a new access; the block SHALL re-arbitrate in that cycle.
REQ-027 inst_stall SHALL equal inst_req & ~inst_data_ok, and data_stall SHALL equal data_req & ~data_data_ok.

Reset
REQ-028 While rst=0 at a clock edge, the FSM SHALL enter IDLE, the owner SHALL become inst, and all latched fields SHALL become 0.
REQ-029 All outputs SHALL be 0 in reset, except the rdata pass-throughs.
REQ-030 Reset mid-transaction SHALL abandon the transaction without pulsing any *_data_ok.

Structure
REQ-031 State encodings and the size codes (0/1/2) SHALL live in the shared defines header, next to the opcode defines.
REQ-032 The block SHALL be a single module with no sub-modules; the latched request fields SHALL be one register group updated on grant.

Verification
REQ-033 Scenario: inst_req only, addr 0xBFC00000, addr_ok at +2, data_ok at +4 with rdata 0x24080001 -> bus_req high 2 cycles, inst_data_ok pulses 1 cycle with 0x24080001.
REQ-034 Scenario: inst_req and data_req (wr=1, addr 0x80000010, wdata 0xDEADBEEF, size 2) in the same cycle -> data transaction first with bus_wr=1; inst granted after data_data_ok; inst_stall high throughout.
REQ-035 Scenario: bus_addr_ok and bus_data_ok in the same ADDR cycle -> completion that cycle, FSM in IDLE next cycle.
REQ-036 Scenario: data_addr changed while in ADDR -> bus_addr keeps the latched value.
REQ-037 Scenario: rst=0 asserted while in DATA, then bus_data_ok=1 after release -> no *_data_ok pulse, FSM stays IDLE.
REQ-038 Scenario: byte store, size 0, addr 0x80000003 -> bus_size=0 and bus_addr=0x80000003, unchanged.
